// File: rtl/gate_led_tester.sv
// Board bring-up harness for the primitive gate library: debounced buttons drive
// gate operands, gate results are shown on PWM-dimmed LEDs with a stepped brightness.
module gate_led_tester #(
    parameter int unsigned NUM_LEDS        = 5,
    parameter int unsigned PWM_BITS        = 8,
    parameter int unsigned DUTY_BASE       = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 12000
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                BTN1,
    input  logic                BTN2,
    input  logic                BTN3,
    output logic [NUM_LEDS-1:0] LED,
    output logic [1:0]          LEVEL
);

    localparam int unsigned NUM_BTN     = 3;
    localparam int unsigned CW          = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned DW          = PWM_BITS + 1;
    localparam int unsigned FULL_DUTY   = 1 << PWM_BITS;
    localparam int unsigned MID_RAW     = DUTY_BASE * 4;
    localparam int unsigned BRIGHT_RAW  = DUTY_BASE * 16;
    localparam int unsigned MID_DUTY    = (MID_RAW < FULL_DUTY) ? MID_RAW : FULL_DUTY;
    localparam int unsigned BRIGHT_DUTY = (BRIGHT_RAW < FULL_DUTY) ? BRIGHT_RAW : FULL_DUTY;

    typedef enum logic [1:0] {
        LVL_DIM    = 2'd0,
        LVL_MID    = 2'd1,
        LVL_BRIGHT = 2'd2,
        LVL_FULL   = 2'd3
    } level_e;

    logic [NUM_BTN-1:0]         btn_raw;
    logic [NUM_BTN-1:0]         meta_q;
    logic [NUM_BTN-1:0]         sync_q;
    logic [NUM_BTN-1:0]         deb_q;
    logic [NUM_BTN-1:0]         deb_d;
    logic [NUM_BTN-1:0][CW-1:0] cnt_q;
    logic [NUM_BTN-1:0][CW-1:0] cnt_d;

    level_e                     state_q;
    level_e                     state_d;
    logic                       d3_prev_q;
    logic                       step_c;

    logic [PWM_BITS-1:0]        pwm_q;
    logic [DW-1:0]              duty_c;
    logic                       pwm_on_c;

    logic                       op_a;
    logic                       op_b;
    logic [NUM_LEDS-1:0]        gate_c;
    logic [NUM_LEDS-1:0]        led_q;

    assign btn_raw = {BTN3, BTN2, BTN1};

    // Two-flop synchroniser for the asynchronous buttons
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= btn_raw;
            sync_q <= meta_q;
        end
    end

    // Debounce: accept a new value only after DEBOUNCE_CYCLES consecutive differing cycles
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (sync_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d[i] = sync_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            deb_q <= '0;
            cnt_q <= '0;
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    // Brightness level FSM: state register plus press-edge history
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= LVL_DIM;
            d3_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            d3_prev_q <= deb_q[2];
        end
    end

    assign step_c = deb_q[2] & ~d3_prev_q;

    always_comb begin
        state_d = state_q;
        if (step_c) begin
            unique case (state_q)
                LVL_DIM:    state_d = LVL_MID;
                LVL_MID:    state_d = LVL_BRIGHT;
                LVL_BRIGHT: state_d = LVL_FULL;
                LVL_FULL:   state_d = LVL_DIM;
                default:    state_d = LVL_DIM;
            endcase
        end
    end

    // Level outputs: debug LEVEL and the saturated duty for the PWM compare
    always_comb begin
        LEVEL  = state_q;
        duty_c = DW'(DUTY_BASE);
        unique case (state_q)
            LVL_DIM:    duty_c = DW'(DUTY_BASE);
            LVL_MID:    duty_c = DW'(MID_DUTY);
            LVL_BRIGHT: duty_c = DW'(BRIGHT_DUTY);
            LVL_FULL:   duty_c = DW'(FULL_DUTY);
            default:    duty_c = DW'(DUTY_BASE);
        endcase
    end

    // Free-running PWM counter; wraps naturally at its width
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_q + PWM_BITS'(1);
        end
    end

    assign pwm_on_c = ({1'b0, pwm_q} < duty_c);

    function automatic logic gate_bit(input int unsigned idx, input logic a, input logic b);
        logic r;
        r = 1'b0;
        unique case (idx)
            0:       r = ~(a & b);
            1:       r = ~a;
            2:       r = a & b;
            3:       r = a | b;
            4:       r = a ^ b;
            5:       r = ~(a ^ b);
            6:       r = ~(a | b);
            7:       r = a;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign op_a = deb_q[0];
    assign op_b = deb_q[1];

    // Only the channels that exist on this board are generated
    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_gate
        assign gate_c[g] = gate_bit(g, op_a, op_b);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            led_q <= '0;
        end else begin
            led_q <= {NUM_LEDS{pwm_on_c}} & gate_c;
        end
    end

    assign LED = led_q;

endmodule
